// File: rtl/qu_rob_if.sv
// Port bundle for the Qu reorder buffer: dispatch, issue, writeback, lookup and commit.
// master = core side driving requests, slave = the ROB itself.
interface qu_rob_if #(
    parameter int ROB_DEPTH         = 8,
    parameter int ROB_ADDR_WIDTH    = $clog2(ROB_DEPTH),
    parameter int PHY_RF_ADDR_WIDTH = 7,
    parameter int DATA_WIDTH        = 32
);
    logic                         flush;
    logic                         alloc_valid;
    logic                         alloc_ready;
    logic [PHY_RF_ADDR_WIDTH-1:0] alloc_dest;
    logic [ROB_ADDR_WIDTH-1:0]    alloc_addr;
    logic                         issue_valid;
    logic [ROB_ADDR_WIDTH-1:0]    issue_addr;
    logic                         wb_valid;
    logic [ROB_ADDR_WIDTH-1:0]    wb_addr;
    logic [DATA_WIDTH-1:0]        wb_value;
    logic [ROB_ADDR_WIDTH-1:0]    lk_addr;
    logic                         lk_ready;
    logic [DATA_WIDTH-1:0]        lk_value;
    logic                         commit_valid;
    logic                         commit_ready;
    logic [ROB_ADDR_WIDTH-1:0]    commit_addr;
    logic [PHY_RF_ADDR_WIDTH-1:0] commit_dest;
    logic [DATA_WIDTH-1:0]        commit_value;
    logic [ROB_ADDR_WIDTH:0]      count;
    logic                         empty;

    modport master (
        output flush, alloc_valid, alloc_dest, issue_valid, issue_addr,
               wb_valid, wb_addr, wb_value, lk_addr, commit_ready,
        input  alloc_ready, alloc_addr, lk_ready, lk_value, commit_valid,
               commit_addr, commit_dest, commit_value, count, empty
    );

    modport slave (
        input  flush, alloc_valid, alloc_dest, issue_valid, issue_addr,
               wb_valid, wb_addr, wb_value, lk_addr, commit_ready,
        output alloc_ready, alloc_addr, lk_ready, lk_value, commit_valid,
               commit_addr, commit_dest, commit_value, count, empty
    );
endinterface

// File: rtl/qu_rob.sv
// Qu reorder buffer: circular FIFO of {value, dest, state} cells, in-order commit.
// Optional QU_ROB_WB_BYPASS_EN forwards a same-cycle writeback onto the lookup port.
module qu_rob #(
    parameter int ROB_DEPTH         = 8,
    parameter int ROB_ADDR_WIDTH    = $clog2(ROB_DEPTH),
    parameter int PHY_RF_ADDR_WIDTH = 7,
    parameter int DATA_WIDTH        = 32
) (
    input logic    clk,
    input logic    rst_n,
    qu_rob_if.slave bus
);
    typedef enum logic [1:0] {
        ST_EMPTY   = 2'b00,
        ST_RETIRED = 2'b01,
        ST_EXECUTE = 2'b10,
        ST_PENDING = 2'b11
    } rob_state_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0]        value;
        logic [PHY_RF_ADDR_WIDTH-1:0] dest;
        rob_state_t                   state;
    } rob_cell_t;

    rob_cell_t                 cells [ROB_DEPTH];
    logic [ROB_ADDR_WIDTH:0]   head, tail, occ;
    logic [ROB_ADDR_WIDTH-1:0] head_idx, tail_idx;
    logic                      alloc_fire, commit_valid, commit_fire;

    assign head_idx = head[ROB_ADDR_WIDTH-1:0];
    assign tail_idx = tail[ROB_ADDR_WIDTH-1:0];
    // Pointers carry a wrap bit, so the modular difference is the occupancy 0..ROB_DEPTH.
    assign occ      = tail - head;

    assign bus.count       = occ;
    assign bus.empty       = (head == tail);
    assign bus.alloc_ready = (occ != (ROB_ADDR_WIDTH+1)'(ROB_DEPTH));
    assign bus.alloc_addr  = tail_idx;

    assign commit_valid     = !bus.empty && (cells[head_idx].state == ST_RETIRED) && !bus.flush;
    assign commit_fire      = commit_valid && bus.commit_ready;
    assign alloc_fire       = bus.alloc_valid && bus.alloc_ready && !bus.flush;
    assign bus.commit_valid = commit_valid;
    assign bus.commit_addr  = head_idx;
    assign bus.commit_dest  = cells[head_idx].dest;
    assign bus.commit_value = cells[head_idx].value;

`ifdef QU_ROB_WB_BYPASS_EN
    logic lk_fwd;
    // state[1] set means PENDING or EXECUTE, i.e. still waiting for a result.
    assign lk_fwd       = bus.wb_valid && (bus.wb_addr == bus.lk_addr) && cells[bus.lk_addr].state[1];
    assign bus.lk_ready = lk_fwd || (cells[bus.lk_addr].state == ST_RETIRED);
    assign bus.lk_value = lk_fwd ? bus.wb_value : cells[bus.lk_addr].value;
`else
    assign bus.lk_ready = (cells[bus.lk_addr].state == ST_RETIRED);
    assign bus.lk_value = cells[bus.lk_addr].value;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head <= '0;
            tail <= '0;
            for (int i = 0; i < ROB_DEPTH; i++) cells[i] <= '0;
        end else if (bus.flush) begin
            head <= '0;
            tail <= '0;
            for (int i = 0; i < ROB_DEPTH; i++) cells[i].state <= ST_EMPTY;
        end else begin
            for (int i = 0; i < ROB_DEPTH; i++) begin
                // The allocated cell is always EMPTY, so it never collides with the other updates.
                if (alloc_fire && tail_idx == ROB_ADDR_WIDTH'(i)) begin
                    cells[i].value <= '0;
                    cells[i].dest  <= bus.alloc_dest;
                    cells[i].state <= ST_PENDING;
                end else if (bus.wb_valid && bus.wb_addr == ROB_ADDR_WIDTH'(i) && cells[i].state[1]) begin
                    cells[i].value <= bus.wb_value;
                    cells[i].state <= ST_RETIRED;
                end else if (bus.issue_valid && bus.issue_addr == ROB_ADDR_WIDTH'(i)
                             && cells[i].state == ST_PENDING) begin
                    cells[i].state <= ST_EXECUTE;
                end else if (commit_fire && head_idx == ROB_ADDR_WIDTH'(i)) begin
                    cells[i].state <= ST_EMPTY;
                end
            end
            if (alloc_fire)  tail <= tail + 1'b1;
            if (commit_fire) head <= head + 1'b1;
        end
    end
endmodule

// File: tb/tb_qu_rob.sv
// Directed vector bench for qu_rob: table of per-cycle inputs and expected outputs, plus mid-run reset.
module tb_qu_rob;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    qu_rob_if #(.ROB_DEPTH(8), .PHY_RF_ADDR_WIDTH(7), .DATA_WIDTH(32)) bus ();

    qu_rob #(.ROB_DEPTH(8), .PHY_RF_ADDR_WIDTH(7), .DATA_WIDTH(32)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        logic fl; logic av; logic [6:0] ad; logic iv; logic [2:0] ia;
        logic wv; logic [2:0] wa; logic [31:0] wd; logic [2:0] la; logic cr;
        logic [3:0] cnt; logic ar; logic [2:0] aa; logic cv; logic [2:0] ca;
        logic [6:0] cd; logic [31:0] cvl; logic lr; logic [31:0] lv;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        logic fl, logic av, logic [6:0] ad, logic iv, logic [2:0] ia,
        logic wv, logic [2:0] wa, logic [31:0] wd, logic [2:0] la, logic cr,
        logic [3:0] cnt, logic ar, logic [2:0] aa, logic cv, logic [2:0] ca,
        logic [6:0] cd, logic [31:0] cvl, logic lr, logic [31:0] lv);
        vec_t v;
        v.fl = fl; v.av = av; v.ad = ad; v.iv = iv; v.ia = ia;
        v.wv = wv; v.wa = wa; v.wd = wd; v.la = la; v.cr = cr;
        v.cnt = cnt; v.ar = ar; v.aa = aa; v.cv = cv; v.ca = ca;
        v.cd = cd; v.cvl = cvl; v.lr = lr; v.lv = lv;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec %0d got %0h want %0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.flush        = v.fl;
        bus.alloc_valid  = v.av;
        bus.alloc_dest   = v.ad;
        bus.issue_valid  = v.iv;
        bus.issue_addr   = v.ia;
        bus.wb_valid     = v.wv;
        bus.wb_addr      = v.wa;
        bus.wb_value     = v.wd;
        bus.lk_addr      = v.la;
        bus.commit_ready = v.cr;
    endtask

    task automatic compare(input vec_t v, input int idx);
        chk("count",        idx, 32'(bus.count),        32'(v.cnt));
        chk("empty",        idx, 32'(bus.empty),        32'(v.cnt == 4'd0));
        chk("alloc_ready",  idx, 32'(bus.alloc_ready),  32'(v.ar));
        chk("alloc_addr",   idx, 32'(bus.alloc_addr),   32'(v.aa));
        chk("commit_valid", idx, 32'(bus.commit_valid), 32'(v.cv));
        chk("commit_addr",  idx, 32'(bus.commit_addr),  32'(v.ca));
        chk("commit_dest",  idx, 32'(bus.commit_dest),  32'(v.cd));
        chk("commit_value", idx, bus.commit_value,      v.cvl);
        chk("lk_ready",     idx, 32'(bus.lk_ready),     32'(v.lr));
        chk("lk_value",     idx, bus.lk_value,          v.lv);
    endtask

    initial begin
        vec_t idle;
        logic       byp_rdy;
        logic [31:0] byp_val;
`ifdef QU_ROB_WB_BYPASS_EN
        byp_rdy = 1'b1; byp_val = 32'hDEAD;
`else
        byp_rdy = 1'b0; byp_val = 32'h0;
`endif
        //          fl av ad  iv ia wv wa wd            la cr | cnt ar aa cv ca cd  cvl           lr lv
        tbl.push_back(mk(0,0,0,  0,0,0,0,32'h0,       0,0,   0,1,0,0,0,0, 32'h0,        0,32'h0));
        tbl.push_back(mk(0,1,5,  0,0,0,0,32'h0,       0,0,   0,1,0,0,0,0, 32'h0,        0,32'h0));
        tbl.push_back(mk(0,1,6,  0,0,0,0,32'h0,       0,0,   1,1,1,0,0,5, 32'h0,        0,32'h0));
        tbl.push_back(mk(0,1,7,  0,0,0,0,32'h0,       0,0,   2,1,2,0,0,5, 32'h0,        0,32'h0));
        tbl.push_back(mk(0,0,0,  0,0,1,1,32'hAA,      0,0,   3,1,3,0,0,5, 32'h0,        0,32'h0));
        tbl.push_back(mk(0,0,0,  0,0,1,0,32'h55,      1,1,   3,1,3,0,0,5, 32'h0,        1,32'hAA));
        tbl.push_back(mk(0,0,0,  0,0,0,0,32'h0,       1,1,   3,1,3,1,0,5, 32'h55,       1,32'hAA));
        tbl.push_back(mk(0,0,0,  0,0,0,0,32'h0,       1,1,   2,1,3,1,1,6, 32'hAA,       1,32'hAA));
        tbl.push_back(mk(0,0,0,  0,0,0,0,32'h0,       1,0,   1,1,3,0,2,7, 32'h0,        0,32'hAA));
        tbl.push_back(mk(0,1,8,  0,0,0,0,32'h0,       2,0,   1,1,3,0,2,7, 32'h0,        0,32'h0));
        tbl.push_back(mk(0,1,9,  0,0,0,0,32'h0,       2,0,   2,1,4,0,2,7, 32'h0,        0,32'h0));
        tbl.push_back(mk(0,1,10, 0,0,1,3,32'h33,      2,0,   3,1,5,0,2,7, 32'h0,        0,32'h0));
        // flush together with writeback, allocate and commit_ready
        tbl.push_back(mk(1,1,11, 0,0,1,2,32'h77,      3,1,   4,1,6,0,2,7, 32'h0,        1,32'h33));
        // writeback to an EMPTY entry is ignored
        tbl.push_back(mk(0,0,0,  0,0,1,3,32'h1234,    3,0,   0,1,0,0,0,5, 32'h55,       0,32'h33));
        tbl.push_back(mk(0,1,20, 0,0,0,0,32'h0,       3,0,   0,1,0,0,0,5, 32'h55,       0,32'h33));
        for (int i = 1; i < 8; i++)
            tbl.push_back(mk(0,1,7'(20+i), 0,0,0,0,32'h0, 7,0, 4'(i),1,3'(i),0,0,20, 32'h0, 0,32'h0));
        // full: alloc blocked; same-cycle issue + writeback on entry 0 ends RETIRED
        tbl.push_back(mk(0,1,30, 1,0,1,0,32'h100,     1,0,   8,0,0,0,0,20,32'h0,        0,32'h0));
        tbl.push_back(mk(0,1,30, 0,0,0,0,32'h0,       0,1,   8,0,0,1,0,20,32'h100,      1,32'h100));
        tbl.push_back(mk(0,1,30, 0,0,0,0,32'h0,       0,1,   7,1,0,0,1,21,32'h0,        0,32'h100));
        tbl.push_back(mk(0,0,0,  0,0,0,0,32'h0,       0,0,   8,0,1,0,1,21,32'h0,        0,32'h0));
        tbl.push_back(mk(0,0,0,  1,2,0,0,32'h0,       2,0,   8,0,1,0,1,21,32'h0,        0,32'h0));
        tbl.push_back(mk(0,0,0,  0,0,1,2,32'hDEAD,    2,0,   8,0,1,0,1,21,32'h0,        byp_rdy,byp_val));
        tbl.push_back(mk(0,0,0,  1,2,0,0,32'h0,       2,0,   8,0,1,0,1,21,32'h0,        1,32'hDEAD));
        tbl.push_back(mk(0,0,0,  0,0,1,1,32'h11,      2,0,   8,0,1,0,1,21,32'h0,        1,32'hDEAD));
        // commit outputs hold while not accepted
        tbl.push_back(mk(0,0,0,  0,0,0,0,32'h0,       2,0,   8,0,1,1,1,21,32'h11,       1,32'hDEAD));
        tbl.push_back(mk(0,0,0,  0,0,0,0,32'h0,       2,0,   8,0,1,1,1,21,32'h11,       1,32'hDEAD));
        tbl.push_back(mk(0,0,0,  0,0,0,0,32'h0,       2,1,   8,0,1,1,1,21,32'h11,       1,32'hDEAD));
        tbl.push_back(mk(0,0,0,  0,0,0,0,32'h0,       2,0,   7,1,1,1,2,22,32'hDEAD,     1,32'hDEAD));

        idle = tbl[0];
        drive(idle);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            drive(tbl[i]);
            #1;
            compare(tbl[i], i);
        end

        // asynchronous reset mid-operation, checked before any clock edge
        @(negedge clk);
        drive(idle);
        bus.lk_addr = 3'd2;
        #2;
        rst_n = 1'b0;
        #1;
        compare(mk(0,0,0,0,0,0,0,32'h0,2,0, 0,1,0,0,0,0,32'h0,0,32'h0), 100);
        @(negedge clk);
        rst_n = 1'b1;
        // first allocation after reset lands at index 0
        bus.alloc_valid = 1'b1;
        bus.alloc_dest  = 7'd9;
        #1;
        chk("post_reset_alloc_addr", 101, 32'(bus.alloc_addr), 32'd0);
        @(negedge clk);
        bus.alloc_valid = 1'b0;
        #1;
        chk("post_reset_count", 102, 32'(bus.count), 32'd1);
        chk("post_reset_head_dest", 102, 32'(bus.commit_dest), 32'd9);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
